// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite motion controller.
package sprite_pkg;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    POP,
    DONE
  } motion_state_t;

endpackage

// File: rtl/axis_bouncer.sv
// One screen axis: holds position and direction, bounces between 0 and MAX.
module axis_bouncer #(
  parameter int unsigned MAX   = 1024,
  parameter int unsigned SPEED = 4,
  parameter int unsigned W     = 11,
  parameter int unsigned INIT  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] start_val,
  output logic [W-1:0] pos
);

  localparam logic [W:0]   MaxExt   = (W+1)'(MAX);
  localparam logic [W:0]   SpeedExt = (W+1)'(SPEED);
  localparam logic [W-1:0] MaxPos   = W'(MAX);
  localparam logic [W-1:0] SpeedPos = W'(SPEED);
  localparam logic [W-1:0] InitPos  = W'(INIT);

  logic [W-1:0] pos_q, pos_d;
  logic         dir_neg_q, dir_neg_d;
  logic [W:0]   sum;

  // One extra bit so the forward sum can never wrap before the compare.
  assign sum = {1'b0, pos_q} + SpeedExt;

  always_comb begin
    pos_d     = pos_q;
    dir_neg_d = dir_neg_q;
    if (load) begin
      pos_d     = start_val;
      dir_neg_d = 1'b0;
    end else if (step) begin
      if (!dir_neg_q) begin
        if (sum >= MaxExt) begin
          pos_d     = MaxPos;
          dir_neg_d = 1'b1;
        end else begin
          pos_d = sum[W-1:0];
        end
      end else begin
        if ({1'b0, pos_q} <= SpeedExt) begin
          pos_d     = '0;
          dir_neg_d = 1'b0;
        end else begin
          pos_d = pos_q - SpeedPos;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q     <= InitPos;
      dir_neg_q <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      dir_neg_q <= dir_neg_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite animator: bounces the sprite on the frame strobe and runs a timed pop on a hit.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned SCREEN_W   = 1280,
  parameter int unsigned SCREEN_H   = 720,
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned HEIGHT     = 256,
  parameter int unsigned X_SPEED    = 4,
  parameter int unsigned Y_SPEED    = 2,
  parameter int unsigned X_START    = 0,
  parameter int unsigned Y_START    = 0,
  parameter int unsigned POP_FRAMES = 30
) (
  input  logic                pixel_clk_in,
  input  logic                rst_n_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                start_in,
  input  logic                hit_in,
  output logic [HCOUNT_W-1:0] x_out,
  output logic [VCOUNT_W-1:0] y_out,
  output logic                pop_out,
  output logic                active_out,
  output logic                done_out
);

  localparam int unsigned CntW = (POP_FRAMES > 1) ? $clog2(POP_FRAMES) : 1;
  localparam logic [CntW-1:0] PopLast = CntW'(POP_FRAMES - 1);
  localparam logic [VCOUNT_W-1:0] StrobeLine = VCOUNT_W'(SCREEN_H);

  motion_state_t   state_q;
  logic            strobe_q;
  logic            hit_q;
  logic [CntW-1:0] cnt_q;
  logic            pop_q, active_q, done_q;
  logic            load, step;

  // First blanking line, column 0: one pulse per frame.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= (hcount_in == '0) && (vcount_in == StrobeLine);
    end
  end

  assign load = (state_q == IDLE) && start_in;
  assign step = (state_q == MOVE) && strobe_q && !hit_q;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      hit_q    <= 1'b0;
      cnt_q    <= '0;
      pop_q    <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          hit_q <= 1'b0;
          if (start_in) begin
            state_q  <= MOVE;
            active_q <= 1'b1;
          end
        end
        MOVE: begin
          // A hit arriving on the strobe cycle is only latched; it acts next frame.
          if (strobe_q && hit_q) begin
            state_q <= POP;
            pop_q   <= 1'b1;
            cnt_q   <= PopLast;
            hit_q   <= 1'b0;
          end else if (hit_in) begin
            hit_q <= 1'b1;
          end
        end
        POP: begin
          if (strobe_q) begin
            if (cnt_q == '0) begin
              state_q  <= DONE;
              pop_q    <= 1'b0;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_bouncer #(
    .MAX  (SCREEN_W - WIDTH),
    .SPEED(X_SPEED),
    .W    (HCOUNT_W),
    .INIT (X_START)
  ) u_x_axis (
    .clk      (pixel_clk_in),
    .rst_n    (rst_n_in),
    .load     (load),
    .step     (step),
    .start_val(HCOUNT_W'(X_START)),
    .pos      (x_out)
  );

  axis_bouncer #(
    .MAX  (SCREEN_H - HEIGHT),
    .SPEED(Y_SPEED),
    .W    (VCOUNT_W),
    .INIT (Y_START)
  ) u_y_axis (
    .clk      (pixel_clk_in),
    .rst_n    (rst_n_in),
    .load     (load),
    .step     (step),
    .start_val(VCOUNT_W'(Y_START)),
    .pos      (y_out)
  );

  assign pop_out    = pop_q;
  assign active_out = active_q;
  assign done_out   = done_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: default instance plus a near-edge start instance.
module tb_sprite_motion_ctrl;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        start, hit;
  logic        start_b, hit_b;
  logic [10:0] x, x_b;
  logic [9:0]  y, y_b;
  logic        pop, active, done;
  logic        pop_b, active_b, done_b;

  int checks = 0;
  int errors = 0;

  sprite_motion_ctrl dut (
    .pixel_clk_in(clk),
    .rst_n_in    (rst_n),
    .hcount_in   (hcount),
    .vcount_in   (vcount),
    .start_in    (start),
    .hit_in      (hit),
    .x_out       (x),
    .y_out       (y),
    .pop_out     (pop),
    .active_out  (active),
    .done_out    (done)
  );

  sprite_motion_ctrl #(
    .X_START(1020),
    .Y_START(1)
  ) dut_b (
    .pixel_clk_in(clk),
    .rst_n_in    (rst_n),
    .hcount_in   (hcount),
    .vcount_in   (vcount),
    .start_in    (start_b),
    .hit_in      (hit_b),
    .x_out       (x_b),
    .y_out       (y_b),
    .pop_out     (pop_b),
    .active_out  (active_b),
    .done_out    (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  // Strobe line for one cycle; returns at the negedge just after outputs update.
  task automatic frame(input logic hit_at_strobe);
    hcount = 11'd0;
    vcount = 10'd720;
    cyc();
    hcount = 11'd1;
    vcount = 10'd0;
    hit    = hit_at_strobe;
    cyc();
    hit = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (x !== 11'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", x); end
    checks++; if (y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y); end
    checks++;
    if ({pop, active, done} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {pop, active, done});
    end
    checks++; if (x_b !== 11'd1020) begin errors++; $display("FAIL reset_xb: got %0d want 1020", x_b); end
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_start_move();
    pulse_start();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL start_active: got %b want 1", active); end
    for (int i = 0; i < 5; i++) frame(1'b0);
    checks++; if (x !== 11'd20) begin errors++; $display("FAIL move5_x: got %0d want 20", x); end
    checks++; if (y !== 10'd10) begin errors++; $display("FAIL move5_y: got %0d want 10", y); end
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL move5_pop: got %b want 0", pop); end
    repeat (4) cyc();
    checks++; if (x !== 11'd20) begin errors++; $display("FAIL between_strobes_x: got %0d want 20", x); end
  endtask

  task automatic test_hit_mid_frame();
    for (int i = 0; i < 5; i++) frame(1'b0);
    checks++; if (x !== 11'd40) begin errors++; $display("FAIL pre_hit_x: got %0d want 40", x); end
    pulse_hit();
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL hit_before_strobe_pop: got %b want 0", pop); end
    frame(1'b0);
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL pop_enter: got %b want 1", pop); end
    checks++; if (x !== 11'd40) begin errors++; $display("FAIL pop_freeze_x: got %0d want 40", x); end
    for (int i = 1; i <= 29; i++) frame(1'b0);
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL pop_29: got %b want 1", pop); end
    checks++; if (y !== 10'd20) begin errors++; $display("FAIL pop_freeze_y: got %0d want 20", y); end
    frame(1'b0);
    checks++;
    if ({pop, active, done} !== 3'b001) begin
      errors++; $display("FAIL pop_end: got %b want 001", {pop, active, done});
    end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end
    pulse_hit();
    frame(1'b0);
    checks++; if (x !== 11'd40) begin errors++; $display("FAIL idle_x: got %0d want 40", x); end
    checks++;
    if ({pop, active} !== 2'b00) begin
      errors++; $display("FAIL idle_flags: got %b want 00", {pop, active});
    end
  endtask

  task automatic test_hit_on_strobe();
    pulse_start();
    checks++; if (x !== 11'd0) begin errors++; $display("FAIL restart_x: got %0d want 0", x); end
    frame(1'b0);
    frame(1'b0);
    frame(1'b1);
    checks++; if (x !== 11'd12) begin errors++; $display("FAIL strobe_hit_x: got %0d want 12", x); end
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL strobe_hit_pop: got %b want 0", pop); end
    frame(1'b0);
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL strobe_hit_next_pop: got %b want 1", pop); end
    for (int i = 1; i <= 29; i++) begin
      frame(1'b0);
      if (i == 5) pulse_hit();
      if (i == 10) pulse_start();
    end
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL pop_len_29: got %b want 1", pop); end
    checks++; if (x !== 11'd12) begin errors++; $display("FAIL start_in_pop_x: got %0d want 12", x); end
    frame(1'b0);
    checks++;
    if ({pop, done} !== 2'b01) begin
      errors++; $display("FAIL pop_len_end: got %b want 01", {pop, done});
    end
    cyc();
  endtask

  task automatic test_start_hit_same();
    start = 1'b1;
    hit   = 1'b1;
    cyc();
    start = 1'b0;
    hit   = 1'b0;
    cyc();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL same_active: got %b want 1", active); end
    frame(1'b0);
    frame(1'b0);
    checks++; if (x !== 11'd8) begin errors++; $display("FAIL same_x: got %0d want 8", x); end
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL same_pop: got %b want 0", pop); end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({x, y} !== 21'd0) begin
      errors++; $display("FAIL midop_reset_xy: got %0d/%0d want 0/0", x, y);
    end
    checks++;
    if ({pop, active, done} !== 3'b000) begin
      errors++; $display("FAIL midop_reset_flags: got %b want 000", {pop, active, done});
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_bounce();
    int max_y;
    pulse_start_b();
    checks++;
    if (x_b !== 11'd1020 || y_b !== 10'd1) begin
      errors++; $display("FAIL b_load: got %0d/%0d want 1020/1", x_b, y_b);
    end
    frame(1'b0);
    checks++; if (x_b !== 11'd1024) begin errors++; $display("FAIL b_edge_x: got %0d want 1024", x_b); end
    checks++; if (y_b !== 10'd3) begin errors++; $display("FAIL b_y1: got %0d want 3", y_b); end
    frame(1'b0);
    checks++; if (x_b !== 11'd1020) begin errors++; $display("FAIL b_reverse_x: got %0d want 1020", x_b); end
    max_y = 5;
    for (int n = 3; n <= 465; n++) begin
      frame(1'b0);
      if (int'(y_b) > max_y) max_y = int'(y_b);
      if (n == 232) begin
        checks++; if (y_b !== 10'd464) begin errors++; $display("FAIL b_y_top: got %0d want 464", y_b); end
      end
      if (n == 464) begin
        checks++; if (y_b !== 10'd0) begin errors++; $display("FAIL b_y_floor: got %0d want 0", y_b); end
      end
      if (n == 465) begin
        checks++; if (y_b !== 10'd2) begin errors++; $display("FAIL b_y_rebound: got %0d want 2", y_b); end
      end
    end
    checks++; if (max_y != 464) begin errors++; $display("FAIL b_y_max: got %0d want 464", max_y); end
    checks++; if (active_b !== 1'b1) begin errors++; $display("FAIL b_active: got %b want 1", active_b); end
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n   = 1'b1;
    hcount  = 11'd1;
    vcount  = 10'd0;
    start   = 1'b0;
    hit     = 1'b0;
    start_b = 1'b0;
    hit_b   = 1'b0;
    test_reset();
    test_start_move();
    test_hit_mid_frame();
    test_hit_on_strobe();
    test_start_hit_same();
    test_async_reset();
    test_bounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
